// File: rtl/eth_parser_pkg.sv
// rtl/eth_parser_pkg.sv - frame metadata type shared with ethernet_frame_parser
package eth_parser_pkg;

    typedef struct packed {
        logic [47:0] dest_mac;
        logic [47:0] src_mac;
        logic [15:0] ethertype;
        logic        is_ipv4;
        logic        is_ipv6;
        logic        is_arp;
        logic        is_unknown;
    } eth_metadata_t;

endpackage

// File: rtl/eth_frame_filter.sv
// rtl/eth_frame_filter.sv - per-frame MAC/protocol filter with registered AXI-Stream output
module eth_frame_filter
    import eth_parser_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [47:0]           cfg_local_mac,
    input  logic                  cfg_promisc,
    input  logic                  cfg_accept_mcast,
    input  logic [3:0]            cfg_type_en,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tlast,
    input  eth_metadata_t         s_axis_tuser,
    input  logic                  s_axis_tuser_valid,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output eth_metadata_t         m_axis_tuser,
    output logic [CNT_WIDTH-1:0]  stat_pass_cnt,
    output logic [CNT_WIDTH-1:0]  stat_drop_cnt,
    output logic                  stat_meta_overrun
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PASS,
        ST_DROP
    } state_t;

    state_t                  state_q;
    eth_metadata_t           meta_q;
    logic                    meta_pending_q;
    logic                    overrun_q;
    logic [DATA_WIDTH-1:0]   m_tdata_q;
    logic                    m_tvalid_q;
    logic                    m_tlast_q;
    eth_metadata_t           m_tuser_q;
    logic [CNT_WIDTH-1:0]    pass_cnt_q;
    logic [CNT_WIDTH-1:0]    pass_cnt_d;
    logic [CNT_WIDTH-1:0]    drop_cnt_q;
    logic [CNT_WIDTH-1:0]    drop_cnt_d;

    logic mac_ok;
    logic type_ok;
    logic accept;
    logic out_free;
    logic consume;
    logic s_ready;
    logic s_hs;
    logic last_hs;

    // Decision is evaluated against the pending metadata and the live configuration.
    assign mac_ok  = cfg_promisc
                   || (meta_q.dest_mac == cfg_local_mac)
                   || (&meta_q.dest_mac)
                   || (cfg_accept_mcast && meta_q.dest_mac[40]);
    assign type_ok = |({meta_q.is_unknown, meta_q.is_arp, meta_q.is_ipv6, meta_q.is_ipv4}
                       & cfg_type_en);
    assign accept  = mac_ok && type_ok;

    // The output register is free when empty or draining this cycle; a new frame's
    // metadata must not replace m_axis_tuser while the previous last beat is stalled.
    assign out_free = !m_tvalid_q || m_axis_tready;
    assign consume  = (state_q == ST_IDLE) && meta_pending_q && out_free;

    // Input ready: pass-through throttled by the output register, drop sinks freely.
    always_comb begin
        s_ready = 1'b0;
        case (state_q)
            ST_PASS: s_ready = out_free;
            ST_DROP: s_ready = 1'b1;
            default: s_ready = 1'b0;
        endcase
    end

    assign s_hs    = s_axis_tvalid && s_ready;
    assign last_hs = s_hs && s_axis_tlast;

    // Pending metadata capture; a strobe landing on an unconsumed entry is flagged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q         <= '0;
            meta_pending_q <= 1'b0;
            overrun_q      <= 1'b0;
        end else begin
            if (s_axis_tuser_valid) begin
                meta_q         <= s_axis_tuser;
                meta_pending_q <= 1'b1;
                if (meta_pending_q && !consume) begin
                    overrun_q <= 1'b1;
                end
            end else if (consume) begin
                meta_pending_q <= 1'b0;
            end
        end
    end

    // Frame FSM together with the single-entry output register it feeds.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            m_tdata_q  <= '0;
            m_tvalid_q <= 1'b0;
            m_tlast_q  <= 1'b0;
            m_tuser_q  <= '0;
        end else begin
            if ((state_q == ST_PASS) && s_hs) begin
                m_tdata_q  <= s_axis_tdata;
                m_tlast_q  <= s_axis_tlast;
                m_tvalid_q <= 1'b1;
            end else if (m_axis_tready) begin
                m_tvalid_q <= 1'b0;
            end

            case (state_q)
                ST_IDLE: begin
                    if (consume) begin
                        m_tuser_q <= meta_q;
                        state_q   <= accept ? ST_PASS : ST_DROP;
                    end
                end
                ST_PASS: begin
                    if (last_hs) begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_DROP: begin
                    if (last_hs) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Next-state values of the wrapping frame counters.
    always_comb begin
        pass_cnt_d = pass_cnt_q;
        drop_cnt_d = drop_cnt_q;
        if (last_hs && (state_q == ST_PASS)) begin
            pass_cnt_d = pass_cnt_q + CNT_WIDTH'(1);
        end
        if (last_hs && (state_q == ST_DROP)) begin
            drop_cnt_d = drop_cnt_q + CNT_WIDTH'(1);
        end
    end

    // Statistics counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pass_cnt_q <= '0;
            drop_cnt_q <= '0;
        end else begin
            pass_cnt_q <= pass_cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign s_axis_tready     = s_ready;
    assign m_axis_tdata      = m_tdata_q;
    assign m_axis_tvalid     = m_tvalid_q;
    assign m_axis_tlast      = m_tlast_q;
    assign m_axis_tuser      = m_tuser_q;
    assign stat_pass_cnt     = pass_cnt_q;
    assign stat_drop_cnt     = drop_cnt_q;
    assign stat_meta_overrun = overrun_q;

endmodule

// File: tb/tb_eth_frame_filter.sv
// tb/tb_eth_frame_filter.sv - randomized scoreboard bench for eth_frame_filter
module tb_eth_frame_filter;
    import eth_parser_pkg::*;

    localparam int DW = 8;
    localparam int CW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [47:0]   cfg_local_mac = '0;
    logic          cfg_promisc = 1'b0;
    logic          cfg_accept_mcast = 1'b0;
    logic [3:0]    cfg_type_en = '0;
    logic [DW-1:0] s_tdata = '0;
    logic          s_tvalid = 1'b0;
    logic          s_tready;
    logic          s_tlast = 1'b0;
    eth_metadata_t s_tuser = '0;
    logic          s_tuser_valid = 1'b0;
    logic [DW-1:0] m_tdata;
    logic          m_tvalid;
    logic          m_tready = 1'b0;
    logic          m_tlast;
    eth_metadata_t m_tuser;
    logic [CW-1:0] pass_cnt;
    logic [CW-1:0] drop_cnt;
    logic          overrun;

    always #5 clk = ~clk;

    eth_frame_filter #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk               (clk),
        .rst               (rst),
        .cfg_local_mac     (cfg_local_mac),
        .cfg_promisc       (cfg_promisc),
        .cfg_accept_mcast  (cfg_accept_mcast),
        .cfg_type_en       (cfg_type_en),
        .s_axis_tdata      (s_tdata),
        .s_axis_tvalid     (s_tvalid),
        .s_axis_tready     (s_tready),
        .s_axis_tlast      (s_tlast),
        .s_axis_tuser      (s_tuser),
        .s_axis_tuser_valid(s_tuser_valid),
        .m_axis_tdata      (m_tdata),
        .m_axis_tvalid     (m_tvalid),
        .m_axis_tready     (m_tready),
        .m_axis_tlast      (m_tlast),
        .m_axis_tuser      (m_tuser),
        .stat_pass_cnt     (pass_cnt),
        .stat_drop_cnt     (drop_cnt),
        .stat_meta_overrun (overrun)
    );

    typedef struct packed {
        logic [DW-1:0] d;
        logic          l;
        eth_metadata_t u;
    } beat_t;

    int            total = 0;
    int            bad = 0;
    beat_t         expq[$];
    beat_t         e_b;
    int            exp_pass = 0;
    int            exp_drop = 0;
    int            rdy_mode = 0;
    int            rdy_ph = 0;
    logic          drv_acc_frame = 1'b0;
    logic          stall_prev = 1'b0;
    logic [DW:0]   prev_beat = '0;
    logic [DW-1:0] fdata[16];
    eth_metadata_t metas[16];

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Output ready generator: always, random, or the repeating 1,0,0,1 pattern.
    initial forever begin
        @(posedge clk);
        #1;
        case (rdy_mode)
            0: m_tready = 1'b1;
            1: m_tready = ($urandom_range(0, 3) != 0);
            default: begin
                m_tready = ((rdy_ph % 4) == 0) || ((rdy_ph % 4) == 3);
                rdy_ph++;
            end
        endcase
    end

    // Output monitor: scoreboard pop, stall stability, and backpressure on the input.
    initial forever begin
        @(negedge clk);
        if (rst) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                chk("hold_valid", 128'(m_tvalid), 128'(1));
                chk("hold_beat", 128'({m_tlast, m_tdata}), 128'(prev_beat));
            end
            if (drv_acc_frame && m_tvalid && !m_tready)
                chk("bp_ready", 128'(s_tready), 128'(0));
            if (m_tvalid && m_tready) begin
                if (expq.size() == 0) begin
                    chk("unexp_beat", 128'(m_tvalid), 128'(0));
                end else begin
                    e_b = expq.pop_front();
                    chk("out_beat", 128'({m_tdata, m_tlast, m_tuser}), 128'(e_b));
                end
            end
            stall_prev = m_tvalid && !m_tready;
            prev_beat  = {m_tlast, m_tdata};
        end
    end

    function automatic eth_metadata_t mk_meta(input logic [47:0] dst, input int cls);
        eth_metadata_t m;
        m = '0;
        m.dest_mac = dst;
        m.src_mac  = {16'($urandom), 32'($urandom)};
        case (cls)
            0: begin m.is_ipv4 = 1'b1;    m.ethertype = 16'h0800; end
            1: begin m.is_ipv6 = 1'b1;    m.ethertype = 16'h86DD; end
            2: begin m.is_arp = 1'b1;     m.ethertype = 16'h0806; end
            default: begin m.is_unknown = 1'b1; m.ethertype = 16'h88B5; end
        endcase
        return m;
    endfunction

    function automatic logic [47:0] rand_dest();
        logic [47:0] mac;
        mac = {16'($urandom), 32'($urandom)};
        case ($urandom_range(0, 3))
            0: mac = cfg_local_mac;
            1: mac = 48'hFFFF_FFFF_FFFF;
            2: mac[40] = 1'b1;
            default: mac[40] = 1'b0;
        endcase
        return mac;
    endfunction

    // Reference decision: address class acceptance, then the enable bit of the frame's class.
    function automatic logic model_accept(input eth_metadata_t m);
        logic mac_ok;
        int   cls;
        mac_ok = cfg_promisc || (m.dest_mac == cfg_local_mac)
              || (m.dest_mac == 48'hFFFF_FFFF_FFFF)
              || (cfg_accept_mcast && m.dest_mac[40]);
        cls = m.is_ipv4 ? 0 : m.is_ipv6 ? 1 : m.is_arp ? 2 : 3;
        return mac_ok && cfg_type_en[cls];
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input eth_metadata_t m);
        s_tuser       = m;
        s_tuser_valid = 1'b1;
        cyc();
        s_tuser_valid = 1'b0;
    endtask

    task automatic drive_beat(input logic [DW-1:0] d, input logic last, input logic acc,
                              input eth_metadata_t m, input logic stb, input eth_metadata_t nm);
        int   n;
        logic hs;
        n  = 0;
        hs = 1'b0;
        s_tvalid = 1'b1;
        s_tdata  = d;
        s_tlast  = last;
        if (stb) begin
            s_tuser       = nm;
            s_tuser_valid = 1'b1;
        end
        while (!hs && n < 300) begin
            @(negedge clk);
            hs = s_tready;
            @(posedge clk);
            #1;
            s_tuser_valid = 1'b0;
            n++;
        end
        if (!hs)
            chk("beat_timeout", 128'(hs), 128'(1));
        else if (acc)
            expq.push_back({d, last, m});
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic send_frame(input eth_metadata_t m, input int len, input logic pre,
                              input int eb, input eth_metadata_t nm, input logic gaps);
        logic acc;
        if (!pre) strobe(m);
        acc = model_accept(m);
        drv_acc_frame = acc;
        for (int b = 0; b < len; b++) begin
            if (gaps) repeat ($urandom_range(0, 1)) cyc();
            drive_beat(fdata[b], b == len - 1, acc, m, b == eb, nm);
        end
        if (acc) exp_pass++;
        else     exp_drop++;
        drv_acc_frame = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (expq.size() != 0 && n < 500) begin
            cyc();
            n++;
        end
        chk({tag, "_drain"}, 128'(expq.size()), 128'(0));
        repeat (3) cyc();
        chk({tag, "_pass_cnt"}, 128'(pass_cnt), 128'(exp_pass));
        chk({tag, "_drop_cnt"}, 128'(drop_cnt), 128'(exp_drop));
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_m_tvalid"}, 128'(m_tvalid), 128'(0));
        chk({tag, "_m_tlast"}, 128'(m_tlast), 128'(0));
        chk({tag, "_m_tdata"}, 128'(m_tdata), 128'(0));
        chk({tag, "_m_tuser"}, 128'(m_tuser), 128'(0));
        chk({tag, "_s_tready"}, 128'(s_tready), 128'(0));
        chk({tag, "_pass_cnt"}, 128'(pass_cnt), 128'(0));
        chk({tag, "_drop_cnt"}, 128'(drop_cnt), 128'(0));
        chk({tag, "_overrun"}, 128'(overrun), 128'(0));
    endtask

    // Asynchronous reset pulse launched between clock edges; outputs checked before any edge.
    task automatic async_reset(input string tag);
        #2 rst = 1'b1;
        #1;
        reset_checks(tag);
        s_tvalid      = 1'b0;
        s_tlast       = 1'b0;
        s_tuser_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        expq.delete();
        exp_pass = 0;
        exp_drop = 0;
        drv_acc_frame = 1'b0;
        cyc();
    endtask

    eth_metadata_t m0;
    eth_metadata_t m1;
    int            len;
    int            eb;
    logic          pre;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        reset_checks("reset");
        rst = 1'b0;
        cyc();

        // Local unicast IPv4 frame passes unchanged.
        rdy_mode         = 0;
        cfg_local_mac    = 48'h1122_3344_5566;
        cfg_type_en      = 4'b0001;
        fdata[0] = 8'hDE; fdata[1] = 8'hAD; fdata[2] = 8'hBE; fdata[3] = 8'hEF;
        m0 = mk_meta(48'h1122_3344_5566, 0);
        send_frame(m0, 4, 1'b0, -1, m0, 1'b0);
        drain("ucast");
        chk("ucast_ethertype", 128'(m_tuser.ethertype), 128'(16'h0800));

        // Destination mismatch is swallowed.
        m0 = mk_meta(48'hAABB_CCDD_EEFF, 0);
        send_frame(m0, 4, 1'b0, -1, m0, 1'b0);
        drain("mismatch");

        // Broadcast ARP passes only when ARP is enabled.
        cfg_type_en = 4'b0100;
        m0 = mk_meta(48'hFFFF_FFFF_FFFF, 2);
        send_frame(m0, 4, 1'b0, -1, m0, 1'b0);
        drain("bcast_arp_en");
        cfg_type_en = 4'b0001;
        send_frame(m0, 4, 1'b0, -1, m0, 1'b0);
        drain("bcast_arp_dis");

        // Output backpressure pattern on a passed frame.
        rdy_mode = 2;
        rdy_ph   = 0;
        for (int i = 0; i < 6; i++) fdata[i] = 8'(8'h10 + i);
        m0 = mk_meta(48'h1122_3344_5566, 0);
        send_frame(m0, 6, 1'b0, -1, m0, 1'b0);
        drain("backpressure");

        // Next frame strobed mid-frame; single-beat second frame.
        rdy_mode = 1;
        m1 = mk_meta(48'hFFFF_FFFF_FFFF, 0);
        send_frame(m0, 4, 1'b0, 2, m1, 1'b0);
        fdata[0] = 8'h5A;
        send_frame(m1, 1, 1'b1, -1, m1, 1'b0);
        drain("b2b");
        chk("b2b_overrun", 128'(overrun), 128'(0));

        // Randomized phases with varying configuration.
        for (int p = 0; p < 4; p++) begin
            cfg_local_mac    = {16'($urandom), 32'($urandom)};
            cfg_local_mac[40] = 1'b0;
            cfg_promisc      = ($urandom_range(0, 4) == 0);
            cfg_accept_mcast = 1'($urandom_range(0, 1));
            cfg_type_en      = 4'($urandom_range(1, 15));
            for (int f = 0; f < 15; f++) metas[f] = mk_meta(rand_dest(), $urandom_range(0, 3));
            pre = 1'b0;
            for (int f = 0; f < 15; f++) begin
                len = $urandom_range(1, 6);
                for (int b = 0; b < len; b++) fdata[b] = 8'($urandom);
                eb = (f < 14 && $urandom_range(0, 1) == 1) ? $urandom_range(0, len - 1) : -1;
                send_frame(metas[f], len, pre, eb, metas[(f < 14) ? f + 1 : f], 1'b1);
                pre = (eb >= 0);
            end
            drain("random");
            chk("random_overrun", 128'(overrun), 128'(0));
        end

        // Two strobes while the first frame is still in progress overwrite pending metadata.
        rdy_mode = 0;
        m0 = mk_meta(48'hAABB_CCDD_EEFF, 0);
        strobe(m0);
        repeat (3) cyc();
        strobe(mk_meta(48'hFFFF_FFFF_FFFF, 0));
        strobe(mk_meta(48'hFFFF_FFFF_FFFF, 1));
        chk("overrun_set", 128'(overrun), 128'(1));
        async_reset("overrun_rst");

        // Reset in the middle of a passed frame, with beat 2 of 4 on the input.
        cfg_local_mac = 48'h1122_3344_5566;
        cfg_type_en   = 4'b0001;
        fdata[0] = 8'hC0; fdata[1] = 8'hC1; fdata[2] = 8'hC2; fdata[3] = 8'hC3;
        m0 = mk_meta(48'h1122_3344_5566, 0);
        send_frame(m0, 4, 1'b0, -1, m0, 1'b0);
        strobe(m0);
        drv_acc_frame = 1'b1;
        drive_beat(fdata[0], 1'b0, 1'b1, m0, 1'b0, m0);
        drive_beat(fdata[1], 1'b0, 1'b1, m0, 1'b0, m0);
        s_tvalid = 1'b1;
        s_tdata  = fdata[2];
        chk("midpass_valid", 128'(m_tvalid), 128'(1));
        async_reset("midpass_rst");

        // Clean frame after reset.
        send_frame(m0, 4, 1'b0, -1, m0, 1'b0);
        drain("post_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

endmodule

// File: doc/eth_frame_filter.md
Name: eth_frame_filter

Overview:
- Sits directly downstream of ethernet_frame_parser.
- Consumes the parser's payload AXI-Stream plus its eth_metadata_t sideband.
- Decides once per frame whether to forward or discard the whole frame, based on destination MAC and a protocol-class enable mask.
- Forwarded frames leave through a registered AXI-Stream output with the frame's metadata held alongside. Pass/drop statistics are exported.

Parameters:
- DATA_WIDTH, 8, payload beat width in bits; must match the parser.
- CNT_WIDTH, 32, width of the statistics counters.

Ports:
- clk  in  1  single clock for all logic.
- rst  in  1  reset: one clock; reset is asynchronous and active-high.
- cfg_local_mac  in  48  station MAC address.
- cfg_promisc  in  1  1 = accept every destination MAC.
- cfg_accept_mcast  in  1  1 = accept group addresses (dest_mac[40]=1).
- cfg_type_en  in  4  class enables: bit0 ipv4, bit1 ipv6, bit2 arp, bit3 unknown.
- s_axis_tdata  in  DATA_WIDTH  payload from parser.
- s_axis_tvalid  in  1  payload valid.
- s_axis_tready  out  1  payload ready.
- s_axis_tlast  in  1  last payload beat of frame.
- s_axis_tuser  in  eth_parser_pkg::eth_metadata_t  frame metadata.
- s_axis_tuser_valid  in  1  single-cycle metadata strobe, one per frame.
- m_axis_tdata  out  DATA_WIDTH  forwarded payload.
- m_axis_tvalid  out  1  output valid.
- m_axis_tready  in  1  output ready.
- m_axis_tlast  out  1  output last.
- m_axis_tuser  out  eth_metadata_t  metadata of the frame being forwarded; stable for the whole frame.
- stat_pass_cnt  out  CNT_WIDTH  frames forwarded.
- stat_drop_cnt  out  CNT_WIDTH  frames discarded.
- stat_meta_overrun  out  1  sticky: a metadata strobe overwrote an unconsumed one.

Behaviour:
- Reset (async assert, sync release):
  - State=IDLE; meta_pending=0.
  - All m_axis_* and s_axis_tready = 0; m_axis_tuser = '0.
  - Counters = 0; stat_meta_overrun = 0.
- Metadata capture:
  - s_axis_tuser_valid=1 loads the pending register and sets meta_pending, in any state.
  - If meta_pending is already 1 and is not being consumed that cycle, overwrite the register and set stat_meta_overrun.
- State IDLE:
  - s_axis_tready=0.
  - When meta_pending=1, evaluate the decision, clear meta_pending, copy the pending metadata to m_axis_tuser, and go to PASS (accept=1) or DROP (accept=0).
  - A strobe in the same cycle as consumption refills pending and is not an overrun.
- Decision (combinational on pending metadata; cfg_* sampled in that cycle):
  - mac_ok = cfg_promisc, or dest_mac == cfg_local_mac, or dest_mac == FF:FF:FF:FF:FF:FF, or (cfg_accept_mcast and dest_mac[40]).
  - type_ok = OR of (is_ipv4&en[0], is_ipv6&en[1], is_arp&en[2], is_unknown&en[3]).
  - accept = mac_ok & type_ok.
- State PASS:
  - s_axis_tready = !m_axis_tvalid | m_axis_tready (single output register, no bubbles under continuous ready).
  - Each input handshake loads the output register: m_axis_tvalid=1 the next cycle; data and last copied.
  - The register holds while m_axis_tvalid & !m_axis_tready.
  - On tlast handshake: stat_pass_cnt+1, go to IDLE.
- State DROP:
  - s_axis_tready=1; beats are discarded and the output is untouched.
  - On tlast handshake: stat_drop_cnt+1, go to IDLE.
- Latency:
  - Metadata strobe to first tready = 2 cycles: capture, then IDLE decision, then PASS/DROP.
  - Input beat to output beat = 1 cycle.
- Counters wrap modulo 2^CNT_WIDTH.
- A single-beat frame (tlast on first beat) is legal.
- Back-to-back frames: the next strobe may arrive during PASS/DROP; the decision happens in the IDLE cycle following tlast.
- The last PASS beat may still sit in the output register when IDLE is entered. The next frame's PASS entry must not update m_axis_tuser until that beat has handshaken. IDLE waits on (meta_pending & (!m_axis_tvalid | m_axis_tready)).
- Reset mid-frame discards everything in flight, including the partial frame and pending metadata.

Test Plan:
- Local unicast IPv4: cfg_local_mac=112233445566, cfg_type_en=4'b0001; metadata dest=112233445566, ethertype 0800, is_ipv4; payload DE AD BE EF (last on EF) -> identical 4 beats on m_axis, m_axis_tuser.ethertype=0800, stat_pass_cnt=1.
- MAC mismatch: dest=AABBCCDDEEFF, promisc=0, mcast=0 -> no m_axis_tvalid, 4 beats accepted with tready=1, stat_drop_cnt=1.
- Broadcast ARP with en=4'b0100: dest=FFFFFFFFFFFF, is_arp -> passed. Same frame with en=4'b0001 -> dropped.
- Backpressure: m_axis_tready toggles 1,0,0,1 on a passed frame -> no beat lost or duplicated; tdata stable while stalled; s_axis_tready=0 whenever the output register is full and not draining.
- Back-to-back frames: frame 2 strobe arrives mid-frame-1 -> frame 2 decided after frame 1 tlast; both counted; stat_meta_overrun=0. Two strobes with no payload between -> stat_meta_overrun=1.
- Reset asserted mid-PASS on beat 2 of 4 -> all outputs 0 asynchronously, counters 0; a following clean frame passes normally.
